// File: rtl/ps2_keycode_rx_if.sv
// PS/2 keycode receiver bus: raw keyboard pins in, decoded key state out.
// The master side is the receiver; the slave side is the keyboard/consumer view.
interface ps2_keycode_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic [7:0] rx_byte;
    logic       code_strobe;
    logic       frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output keycode,
        output rx_byte,
        output code_strobe,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  keycode,
        input  rx_byte,
        input  code_strobe,
        input  frame_err
    );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes the keyboard lines, deframes 11-bit
// frames and tracks make/break sequences into a held-key code.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keycode_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    ps2_keycode_rx_if.master  bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic          clk_meta, clk_sync, clk_prev;
    logic          data_meta, data_sync;
    logic          fall_c;
    logic          par_ok_c;
    logic          accept_c;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tcnt;
    logic          break_pending;
    logic [7:0]    keycode_q;
    logic [7:0]    rx_byte_q;
    logic          strobe_q;
    logic          err_q;

    // Two-flop synchronizers for both lines plus the clock-edge history register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= bus.ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= bus.ps2_data;
            data_sync <= data_meta;
        end
    end

    assign fall_c   = !clk_sync && clk_prev;
    // Odd parity over data plus parity bit; ignored unless the check is enabled.
    assign par_ok_c = ^{shift_q, par_q};
    assign accept_c = data_sync && (par_ok_c || !PAR_CHECK);

    // Frame state machine, timeout watchdog and make/break decoder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            tcnt          <= '0;
            break_pending <= 1'b0;
            keycode_q     <= '0;
            rx_byte_q     <= '0;
            strobe_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            if (fall_c) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_sync) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift_q <= {data_sync, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q <= data_sync;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (accept_c) begin
                            rx_byte_q <= shift_q;
                            strobe_q  <= 1'b1;
                            if (shift_q == 8'hE0) begin
                                // Extended prefix: no effect on held key or break state.
                            end else if (shift_q == 8'hF0) begin
                                break_pending <= 1'b1;
                            end else if (break_pending) begin
                                break_pending <= 1'b0;
                                if (shift_q == keycode_q) begin
                                    keycode_q <= 8'h00;
                                end
                            end else begin
                                keycode_q <= shift_q;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tcnt == TW'(TIMEOUT_CYCLES)) begin
                    state <= IDLE;
                    err_q <= 1'b1;
                    tcnt  <= '0;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

    assign bus.keycode     = keycode_q;
    assign bus.rx_byte     = rx_byte_q;
    assign bus.code_strobe = strobe_q;
    assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: directed make/break sequences,
// timeout and mid-frame reset, then randomized frames against a key model.
module tb_ps2_keycode_rx;

    localparam int unsigned TO = 100;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic clk;
    logic reset;
    ps2_keycode_rx_if bus ();

    ps2_keycode_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // Pulse bookkeeping sampled away from the active edge.
    int n_strobe = 0;
    int n_err    = 0;
    int n_both   = 0;
    int cyc      = 0;
    int last_fall = 0;

    // Reference model state.
    logic [7:0] m_key;
    logic [7:0] m_rx;
    bit         m_brk;
    int         e_strobe;
    int         e_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.code_strobe) n_strobe <= n_strobe + 1;
            if (bus.frame_err)   n_err    <= n_err + 1;
            if (bus.code_strobe && bus.frame_err) n_both <= n_both + 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit: data set while the clock is high, then a low phase.
    task automatic send_bit(input bit v);
        int h;
        h = int'($urandom_range(5, 12));
        bus.ps2_data = v;
        repeat (h) @(negedge clk);
        bus.ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (h) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    // Apply the decoding rules to one complete frame.
    task automatic model_frame(input logic [7:0] b, input bit flip, input bit stop);
        bit ok;
        ok = stop && (!PCHK || !flip);
        if (!ok) begin
            e_err++;
        end else begin
            e_strobe++;
            m_rx = b;
            if (b == 8'hE0) begin
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else if (m_brk) begin
                m_brk = 1'b0;
                if (b == m_key) m_key = 8'h00;
            end else begin
                m_key = b;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip, input bit stop);
        bit p;
        p = ~(^b) ^ flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(stop);
        bus.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        model_frame(b, flip, stop);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_key"},     32'(bus.keycode), 32'(m_key));
        check({tag, "_rx"},      32'(bus.rx_byte), 32'(m_rx));
        check({tag, "_strobes"}, 32'(n_strobe),    32'(e_strobe));
        check({tag, "_errs"},    32'(n_err),       32'(e_err));
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input bit flip = 1'b0, input bit stop = 1'b1);
        send_frame(b, flip, stop);
        check_state(tag);
    endtask

    initial begin
        bit         found;
        int         lat;
        logic [7:0] b;
        int         sel;

        reset        = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        m_key = 8'h00; m_rx = 8'h00; m_brk = 1'b0; e_strobe = 0; e_err = 0;
        repeat (3) @(negedge clk);
        check("rst_key",    32'(bus.keycode),     32'h0);
        check("rst_rx",     32'(bus.rx_byte),     32'h0);
        check("rst_strobe", 32'(bus.code_strobe), 32'h0);
        check("rst_err",    32'(bus.frame_err),   32'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Make, break, mismatched break, extended sequences.
        frame("make1d", 8'h1D);
        frame("brk_f0", 8'hF0);
        check("brk_f0_hold", 32'(bus.keycode), 32'h1D);
        frame("brk_1d", 8'h1D);
        check("brk_1d_clear", 32'(bus.keycode), 32'h00);
        frame("held1d", 8'h1D);
        frame("mis_f0", 8'hF0);
        frame("mis_75", 8'h75);
        check("mis_hold", 32'(bus.keycode), 32'h1D);
        frame("make75", 8'h75);
        frame("rep75", 8'h75);
        frame("ext_e0a", 8'hE0);
        frame("ext_75a", 8'h75);
        frame("ext_e0b", 8'hE0);
        frame("ext_f0", 8'hF0);
        frame("ext_75b", 8'h75);
        check("ext_clear", 32'(bus.keycode), 32'h00);

        // Wrong parity, then a missing stop bit.
        frame("par_bad", 8'h1D, 1'b1, 1'b1);
        frame("stop_bad", 8'h75, 1'b0, 1'b0);

        // Partial frame: start plus three data bits, then silence.
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus.frame_err) begin
                found = 1'b1;
                lat   = cyc - last_fall;
            end
        end
        e_err++;
        check("to_seen", 32'(found), 32'h1);
        check("to_window", 32'(lat >= 98 && lat <= 110), 32'h1);
        repeat (3) @(negedge clk);
        check_state("to_after");
        frame("to_recover", 8'h1D);

        // Reset in the middle of a frame.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        reset = 1'b0;
        m_key = 8'h00; m_rx = 8'h00; m_brk = 1'b0;
        @(negedge clk);
        check("mrst_key",    32'(bus.keycode),     32'h0);
        check("mrst_rx",     32'(bus.rx_byte),     32'h0);
        check("mrst_strobe", 32'(bus.code_strobe), 32'h0);
        check("mrst_err",    32'(bus.frame_err),   32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (TO + 20) @(negedge clk);
        check_state("mrst_quiet");
        frame("mrst_make", 8'h1C);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: b = 8'h1D;
                1: b = 8'h75;
                2: b = 8'hF0;
                3: b = 8'hE0;
                4: b = 8'h1C;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) != 0));
            check_state("rand");
        end

        check("never_both", 32'(n_both), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
